out_channel_checker: RTL
========================

# out_channel_checker

Consumer end of the generated-program `out` channel. It accepts each word written by an `out` instruction through a valid/ready handshake and buffers it in a small FIFO. Each word is compared in order against a loaded table of expected values. When the program reports completion, the block raises `finished` and `success`. It sits beside the program execution core in every FPGA test and replaces the ad-hoc `outMem` comparisons done in the default case.

## Interface
- `MemoryElementWidth`, 12, width of one channel word
- `NOut`, 1, number of expected output words (1..256)
- `Depth`, 4, FIFO entries (power of two, ≥2)
- `clock` input 1: single clock, all logic on posedge
- `reset` input 1: synchronous, active-high
- `load_valid` input 1: write `load_data` into expected[`load_index`]
- `load_index` input $clog2(NOut) (min 1): expected-table index
- `load_data` input MemoryElementWidth: expected value
- `start` input 1: pulse, IDLE→RUN
- `out_valid` input 1: core presents an output word
- `out_data` input MemoryElementWidth: output word
- `out_ready` output 1: checker can accept
- `program_done` input 1: core has executed past its last instruction
- `received` output 9: words accepted since `start`
- `mismatch` output 1: sticky, a compared word differed
- `mismatch_index` output 8: index of the first differing word
- `overflow` output 1: sticky, more than NOut words arrived
- `finished` output 1: check complete
- `success` output 1: valid only while `finished`=1

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset→IDLE.
- IDLE:
  - `load_valid` writes the expected table. Loads in any other state are ignored.
  - `start` clears `received`, `mismatch`, `mismatch_index`, `overflow`, `finished`, `success` and the FIFO, then enters RUN.
- RUN:
  - Push when `out_valid && out_ready`.
  - The checker pops the FIFO head whenever the FIFO is non-empty, one word per cycle.
  - Each popped word is compared with expected[`compare_ptr`], and `compare_ptr` increments.
  - If `compare_ptr` ≥ NOut on a pop, set `overflow` and skip the compare; there is no wrap-around.
  - The first inequality sets `mismatch` and latches `mismatch_index`=`compare_ptr`. Later mismatches leave the index unchanged.
  - `program_done` is latched sticky and moves the state to DRAIN.
- DRAIN: pushes are still accepted. When the FIFO is empty with no pop this cycle, go to DONE.
- DONE:
  - `finished`=1.
  - `success` = !`mismatch` && !`overflow` && `received`==NOut.
  - `out_ready`=0.
  - Stays until `reset` or `start`; `start` re-runs with the same table.
- `received` saturates at 511.

## Timing
- Reset values: `out_ready`=0, `received`=0, `mismatch`=0, `mismatch_index`=0, `overflow`=0, `finished`=0, `success`=0. The expected table is not cleared.
- `out_ready` = (state RUN or DRAIN) && FIFO count < Depth. It depends on the registered count only; a same-cycle pop does not raise it.
- A word accepted at edge t is popped at edge t+1 at the earliest. `mismatch`/`overflow` are visible after edge t+1.
- `received` is visible one cycle after the accepting edge.
- Simultaneous push and pop: the count is unchanged.
- `start` while in RUN or DRAIN is ignored.
- `program_done` together with a final push: the word is counted and checked before DONE.
- The minimum delay from the last push to `finished` is 2 cycles.
- `reset` mid-RUN: next cycle is IDLE with all outputs at reset values.

## Structure
- Package `out_check_pkg`:
  - state enum `out_check_state_t` (IDLE, RUN, DRAIN, DONE)
  - `MemoryElementWidth` default constant
  - `RECEIVED_WIDTH`=9
- Sub-module `out_word_fifo`: parameterised width/depth, synchronous reset, registered count, push/pop/full/empty. The expected table and state machine stay in the top.

## Test plan
- NOut=1, load {2}, start, one push of 2, `program_done` → `finished`=1, `success`=1, `received`=1.
- NOut=3, load {5,6,7}, pushes 5,9,7 → `mismatch`=1, `mismatch_index`=1, `success`=0.
- NOut=2, load {1,2}, pushes 1,2,3 → `overflow`=1, `received`=3, `success`=0.
- NOut=2, load {1,2}, push only 1, `program_done` → `finished`=1, `success`=0, `received`=1.
- Depth=4, hold `out_valid` for 8 words with the FIFO popping → `out_ready` never drops. Force a full FIFO by reset-stalling pops (backpressure model) → `out_ready`=0 at count 4, no words lost.
- `reset` asserted mid-RUN after 2 pushes → all outputs 0 next cycle. Re-start with a retained table and correct words → `success`=1.

Source files
------------

// File: rtl/out_check_pkg.sv
// rtl/out_check_pkg.sv - shared types and constants for the out-channel checker
//
// Contents:
//   out_check_state_t             checker state (IDLE, RUN, DRAIN, DONE)
//   DEFAULT_MEMORY_ELEMENT_WIDTH  default width of one channel word
//   RECEIVED_WIDTH                width of the saturating received counter
package out_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } out_check_state_t;

  localparam int DEFAULT_MEMORY_ELEMENT_WIDTH = 12;
  localparam int RECEIVED_WIDTH               = 9;

endpackage

// File: rtl/out_word_fifo.sv
// rtl/out_word_fifo.sv - small synchronous FIFO buffering channel words
//
// Ports:
//   clock      single clock, posedge
//   reset      synchronous, active-high
//   clear      synchronous flush (same effect as reset, contents kept)
//   push       write push_data at the tail (ignored when full)
//   push_data  word to write
//   pop        drop the head word (ignored when empty)
//   pop_data   current head word
//   full       registered count equals Depth
//   empty      registered count is zero
module out_word_fifo #(
  parameter int Width = 12,
  parameter int Depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AddrWidth = $clog2(Depth);
  localparam logic [AddrWidth:0] FullCount = (AddrWidth + 1)'(Depth);

  logic [Width-1:0]     mem [Depth];
  logic [AddrWidth-1:0] wr_ptr;
  logic [AddrWidth-1:0] rd_ptr;
  logic [AddrWidth:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (count == FullCount);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Depth is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AddrWidth{1'b0}}, do_push} - {{AddrWidth{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/out_channel_checker.sv
// rtl/out_channel_checker.sv - checks the out channel word stream against an expected table
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   load_valid/index/data write the expected table (IDLE only)
//   start                 pulse: clear results and begin a run (IDLE or DONE)
//   out_valid/data/ready  word handshake from the execution core
//   program_done          core has finished; drain remaining words then stop
//   received              words accepted since start (saturating)
//   mismatch              sticky, a compared word differed
//   mismatch_index        index of the first differing word
//   overflow              sticky, more than NOut words arrived
//   finished              check complete
//   success               pass/fail, meaningful while finished=1
module out_channel_checker
  import out_check_pkg::*;
#(
  parameter int MemoryElementWidth = DEFAULT_MEMORY_ELEMENT_WIDTH,
  parameter int NOut               = 1,
  parameter int Depth              = 4,
  localparam int IndexWidth        = (NOut > 1) ? $clog2(NOut) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_valid,
  input  logic [IndexWidth-1:0]         load_index,
  input  logic [MemoryElementWidth-1:0] load_data,
  input  logic                          start,
  input  logic                          out_valid,
  input  logic [MemoryElementWidth-1:0] out_data,
  output logic                          out_ready,
  input  logic                          program_done,
  output logic [RECEIVED_WIDTH-1:0]     received,
  output logic                          mismatch,
  output logic [7:0]                    mismatch_index,
  output logic                          overflow,
  output logic                          finished,
  output logic                          success
);

  localparam logic [RECEIVED_WIDTH-1:0] NOutCount   = RECEIVED_WIDTH'(NOut);
  localparam logic [RECEIVED_WIDTH-1:0] ReceivedMax = '1;

  out_check_state_t state;
  out_check_state_t state_next;

  logic [MemoryElementWidth-1:0] expected [NOut];
  logic [RECEIVED_WIDTH-1:0]     compare_ptr;
  logic [MemoryElementWidth-1:0] fifo_data;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          active;
  logic                          push;
  logic                          pop;
  logic                          start_run;
  logic                          ptr_in_range;

  assign active       = (state == RUN) || (state == DRAIN);
  // Uses the registered FIFO count only, so a same-cycle pop never raises ready.
  assign out_ready    = active && !fifo_full;
  assign push         = out_valid && out_ready;
  assign pop          = active && !fifo_empty;
  assign start_run    = start && ((state == IDLE) || (state == DONE));
  assign ptr_in_range = (compare_ptr < NOutCount);
  assign finished     = (state == DONE);
  assign success      = finished && !mismatch && !overflow && (received == NOutCount);

  out_word_fifo #(
    .Width (MemoryElementWidth),
    .Depth (Depth)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_run),
    .push      (push),
    .push_data (out_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = RUN;
      RUN:   if (program_done) state_next = DRAIN;
      // A push in the last drain cycle would otherwise be counted but never checked.
      DRAIN: if (fifo_empty && !push) state_next = DONE;
      DONE:  if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      received       <= '0;
      mismatch       <= 1'b0;
      mismatch_index <= '0;
      overflow       <= 1'b0;
      compare_ptr    <= '0;
    end else begin
      state <= state_next;
      if (start_run) begin
        received       <= '0;
        mismatch       <= 1'b0;
        mismatch_index <= '0;
        overflow       <= 1'b0;
        compare_ptr    <= '0;
      end else begin
        if (push && (received != ReceivedMax)) received <= received + 1'b1;
        if (pop) begin
          if (ptr_in_range) begin
            if ((fifo_data != expected[compare_ptr[IndexWidth-1:0]]) && !mismatch) begin
              mismatch       <= 1'b1;
              mismatch_index <= compare_ptr[7:0];
            end
            compare_ptr <= compare_ptr + RECEIVED_WIDTH'(1);
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

  // The expected table survives reset so a run can be repeated after one.
  always_ff @(posedge clock) begin
    if (!reset && (state == IDLE) && load_valid && (int'(load_index) < NOut)) begin
      expected[load_index] <= load_data;
    end
  end

endmodule
